// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction field positions
// and constants used by the fetch stage and the opcode decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int unsigned OPCODE_MSB  = 31;
  localparam int unsigned OPCODE_LSB  = 26;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID register. Keeps the PC, issues one
// word request at a time, buffers a single response while decode stalls,
// and flushes everything in flight on a branch/jump redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         hold_vld_q, hold_vld_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;

  logic         slot_free;
  logic         consume;
  logic [31:0]  redir_aligned;

  assign slot_free     = !if_valid_q || !id_stall;
  assign consume       = if_valid_q && !id_stall;
  assign redir_aligned = redirect_pc & ~32'h3;

  // Requests only leave from FETCH, and never in a redirect cycle since
  // the current PC is about to be replaced.
  assign imem_req_valid = (state_q == FETCH) && rst_n && !redirect_valid;
  assign imem_req_addr  = pc_q;

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_opcode   = if_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign if_pc_plus4 = if_pc_q + INSTR_BYTES;

  // Next-state logic: redirect first, otherwise advance the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    hold_vld_d   = hold_vld_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    // Decode took the current instruction; a load below overrides this.
    if (consume) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end

    if (redirect_valid) begin
      pc_d         = redir_aligned;
      if_valid_d   = 1'b0;
      if_instr_d   = NOP_INSTR;
      hold_vld_d   = 1'b0;
      hold_instr_d = NOP_INSTR;
      // A request still in flight must be drained before refetching.
      unique case (state_q)
        WAIT, DROP: state_d = imem_rsp_valid ? FETCH : DROP;
        default:    state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_req_valid && imem_req_ready) begin
            req_pc_d = pc_q;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            pc_d = req_pc_q + INSTR_BYTES;
            if (slot_free) begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rsp_data;
              if_pc_d    = req_pc_q;
              state_d    = FETCH;
            end else begin
              hold_vld_d   = 1'b1;
              hold_instr_d = imem_rsp_data;
              hold_pc_d    = req_pc_q;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            if_valid_d   = hold_vld_q;
            if_instr_d   = hold_instr_q;
            if_pc_d      = hold_pc_q;
            hold_vld_d   = 1'b0;
            hold_instr_d = NOP_INSTR;
            state_d      = FETCH;
          end
        end
        DROP: begin
          if (imem_rsp_valid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and IF/ID registers; reset forgets any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= 32'h0;
      hold_vld_q   <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      hold_vld_q   <= hold_vld_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a per-cycle vector table for the directed
// scenarios, a mid-operation reset sequence, and a random run checked
// against an instruction-stream model of the program order.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        rv;
    logic [31:0] dat;
    logic        st;
    logic        rdv;
    logic [31:0] rpc;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic rv, input logic [31:0] dat,
                              input logic st, input logic rdv, input logic [31:0] rpc,
                              input logic e_reqv, input logic [31:0] e_addr,
                              input logic e_ifv, input logic [31:0] e_instr,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rd = rd; v.rv = rv; v.dat = dat; v.st = st; v.rdv = rdv; v.rpc = rpc;
    v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_ifv = e_ifv;
    v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  // Instruction memory contents used by the random run.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return ((a ^ 32'hA5A5_0000) * 32'h0001_0003) + 32'h1;
  endfunction

  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h4);
  endtask

  // Random-run memory and stream-model state.
  bit          busy;
  int          lat;
  logic [31:0] maddr;
  bit          prev_acc, prev_rsp;
  logic [31:0] prev_addr;
  logic [31:0] exp_pc;
  int          delivered;

  initial begin
    rst_n = 1'b0;
    drive_idle();

    // Directed table: reset release, stall/hold, redirect in WAIT,
    // redirect with rsp+stall, ready low, PC wrap.
    //                rd rv dat            st rdv rpc            reqv addr           ifv instr          pc
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 1, 32'h8C08_0004, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h8C08_0004, 32'h0));
    vecs.push_back(mk(1, 1, 32'h2108_0001, 0, 0, 32'h0,         0, 32'h0000_0004, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h2108_0001, 32'h4));
    vecs.push_back(mk(1, 1, 32'h0128_5020, 1, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h2108_0001, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h2108_0001, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h2108_0001, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h2108_0001, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h2108_0001, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0128_5020, 32'h8));
    vecs.push_back(mk(1, 1, 32'hAC09_0008, 0, 0, 32'h0,         0, 32'h0000_000C, 0, 32'h0,         32'h8));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0010, 1, 32'hAC09_0008, 32'hC));
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'h0000_0043, 0, 32'h0000_0010, 0, 32'h0,         32'hC));
    vecs.push_back(mk(1, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 32'h0000_0040, 0, 32'h0,         32'hC));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0040, 0, 32'h0,         32'hC));
    vecs.push_back(mk(1, 1, 32'h0800_0010, 0, 0, 32'h0,         0, 32'h0000_0040, 0, 32'h0,         32'hC));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0044, 1, 32'h0800_0010, 32'h40));
    vecs.push_back(mk(1, 1, 32'h2222_2222, 1, 1, 32'h0000_0100, 0, 32'h0000_0044, 1, 32'h0800_0010, 32'h40));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h40));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h40));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h40));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h40));
    vecs.push_back(mk(1, 1, 32'h3C01_1234, 0, 0, 32'h0,         0, 32'h0000_0100, 0, 32'h0,         32'h40));
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0000_0104, 1, 32'h3C01_1234, 32'h100));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h100));
    vecs.push_back(mk(1, 1, 32'h0C00_0001, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h0,         32'h100));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h0C00_0001, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h0C00_0001, 32'hFFFF_FFFC));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst_n          = 1'b1;
      imem_req_ready = vecs[i].rd;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].dat;
      id_stall       = vecs[i].st;
      redirect_valid = vecs[i].rdv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_reqv));
      chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].e_ifv));
      chk($sformatf("vec%0d_if_instr", i), if_instr, vecs[i].e_instr);
      chk($sformatf("vec%0d_if_opcode", i), 32'(if_opcode), 32'(vecs[i].e_instr[31:26]));
      chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_if_pc_plus4", i), if_pc_plus4, vecs[i].e_pc + 32'd4);
    end
    chk("lw_opcode", 32'(vecs[2].e_instr[31:26]), 32'(6'b100011));

    // Mid-operation reset: request outstanding, then a late response in FETCH.
    @(posedge clk); #1;
    drive_idle();
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("midrst_if_valid", 32'(if_valid), 32'h0);
    chk("midrst_if_pc_plus4", if_pc_plus4, 32'h4);
    @(posedge clk); #1;
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rsp_req_valid", 32'(imem_req_valid), 32'h1);
    chk("late_rsp_req_addr", imem_req_addr, 32'h0);
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_if_valid", 32'(if_valid), 32'h0);
    chk("late_rsp_if_instr", if_instr, 32'h0);
    chk("late_rsp_still_fetch", 32'(imem_req_valid), 32'h1);

    // Random run against the program-order stream model.
    do_reset();
    busy = 0; lat = 0; maddr = 32'h0;
    prev_acc = 0; prev_rsp = 0; prev_addr = 32'h0;
    exp_pc = 32'h0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      if (prev_rsp) busy = 0;
      if (prev_acc) begin
        busy  = 1;
        maddr = prev_addr;
        lat   = int'($urandom_range(1, 3));
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (busy) begin
        if (lat <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(maddr);
        end else begin
          lat--;
        end
      end
      imem_req_ready = ($urandom_range(0, 9) < 7);
      id_stall       = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           redirect_pc = $urandom & 32'h0000_FFFF;
      @(negedge clk);
      if (imem_req_valid) begin
        chk("rnd_one_outstanding", 32'(busy), 32'h0);
        chk("rnd_req_aligned", 32'(imem_req_addr[1:0]), 32'h0);
      end
      if (!if_valid) chk("rnd_nop_when_invalid", if_instr, 32'h0);
      chk("rnd_opcode", 32'(if_opcode), 32'(if_instr[31:26]));
      chk("rnd_pc_plus4", if_pc_plus4, if_pc + 32'd4);
      if (if_valid && !id_stall) begin
        chk("rnd_stream_pc", if_pc, exp_pc);
        chk("rnd_stream_instr", if_instr, memf(if_pc));
        exp_pc = if_pc + 32'd4;
        delivered++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      prev_acc  = imem_req_valid && imem_req_ready;
      prev_addr = imem_req_addr;
      prev_rsp  = imem_rsp_valid;
    end
    chk("rnd_liveness", 32'(delivered >= 100), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
